// File: rtl/tx_frame_arbiter_if.sv
// Frame-source handshakes and TX FIFO write port shared by tx_frame_arbiter.
// The master side drives the sources and models the FIFO; the slave side is the arbiter.
interface tx_frame_arbiter_if;
    logic       req0_valid;
    logic [7:0] req0_data;
    logic       req0_last;
    logic       req0_ready;
    logic       req1_valid;
    logic [7:0] req1_data;
    logic       req1_last;
    logic       req1_ready;
    logic [7:0] fifo_din;
    logic       fifo_EOD_in;
    logic       fifo_wren;
    logic       fifo_afull;

    modport master (
        output req0_valid, req0_data, req0_last,
        input  req0_ready,
        output req1_valid, req1_data, req1_last,
        input  req1_ready,
        input  fifo_din, fifo_EOD_in, fifo_wren,
        output fifo_afull
    );

    modport slave (
        input  req0_valid, req0_data, req0_last,
        output req0_ready,
        input  req1_valid, req1_data, req1_last,
        output req1_ready,
        output fifo_din, fifo_EOD_in, fifo_wren,
        input  fifo_afull
    );
endinterface

// File: rtl/tx_frame_arbiter.sv
// Round-robin, frame-at-a-time arbiter feeding the RMII TX FIFO: pads short
// frames to MIN_LEN, truncates at MAX_LEN and drains the remainder.
module tx_frame_arbiter #(
    parameter int MIN_LEN = 60,
    parameter int MAX_LEN = 1514,
    parameter int LEN_W   = 11
) (
    input  logic                REF_CLK,
    input  logic                rst,
    input  logic                enable,
    tx_frame_arbiter_if.slave   bus,
    output logic [1:0]          grant,
    output logic                busy,
    output logic [15:0]         frame_count,
    output logic [15:0]         trunc_count
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_XFER  = 2'd1,
        S_PAD   = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t     r_state, w_nxt_state;
    logic [1:0] r_grant, w_nxt_grant;
    logic       r_last_served, w_nxt_ls;
    logic [LEN_W-1:0] r_byte_cnt, w_nxt_cnt, w_cnt_inc;
    logic [7:0] r_din, w_nxt_din;
    logic       r_eod, w_nxt_eod;
    logic       r_wren, w_nxt_wren;
    logic       r_busy, w_nxt_busy;
    logic [15:0] r_frame_cnt, w_nxt_frames;
    logic [15:0] r_trunc_cnt, w_nxt_truncs;

    logic       w_sel_valid, w_sel_last, w_ready0, w_ready1, w_accept, w_pick1;
    logic [7:0] w_sel_data;

    assign w_sel_valid = r_grant[1] ? bus.req1_valid : bus.req0_valid;
    assign w_sel_data  = r_grant[1] ? bus.req1_data  : bus.req0_data;
    assign w_sel_last  = r_grant[1] ? bus.req1_last  : bus.req0_last;
    assign w_ready0    = r_grant[0] && (((r_state == S_XFER) && !bus.fifo_afull) || (r_state == S_DRAIN));
    assign w_ready1    = r_grant[1] && (((r_state == S_XFER) && !bus.fifo_afull) || (r_state == S_DRAIN));
    assign w_accept    = w_sel_valid && (w_ready0 || w_ready1);
    assign w_cnt_inc   = r_byte_cnt + {{(LEN_W-1){1'b0}}, 1'b1};
    // Source 1 wins when it is alone, or on a tie when source 0 was served last.
    assign w_pick1     = bus.req1_valid && (!bus.req0_valid || !r_last_served);

    assign bus.req0_ready  = w_ready0;
    assign bus.req1_ready  = w_ready1;
    assign bus.fifo_din    = r_din;
    assign bus.fifo_EOD_in = r_eod;
    assign bus.fifo_wren   = r_wren;
    assign grant           = r_grant;
    assign busy            = r_busy;
    assign frame_count     = r_frame_cnt;
    assign trunc_count     = r_trunc_cnt;

    // Next-state, FIFO write and counter decisions.
    always_comb begin
        w_nxt_state  = r_state;
        w_nxt_grant  = r_grant;
        w_nxt_ls     = r_last_served;
        w_nxt_cnt    = r_byte_cnt;
        w_nxt_din    = r_din;
        w_nxt_eod    = 1'b0;
        w_nxt_wren   = 1'b0;
        w_nxt_frames = r_frame_cnt;
        w_nxt_truncs = r_trunc_cnt;
        case (r_state)
            S_IDLE: begin
                if (enable && (bus.req0_valid || bus.req1_valid)) begin
                    w_nxt_grant = w_pick1 ? 2'b10 : 2'b01;
                    w_nxt_ls    = w_pick1;
                    w_nxt_cnt   = '0;
                    w_nxt_state = S_XFER;
                end else begin
                    w_nxt_grant = 2'b00;
                end
            end
            S_XFER: begin
                if (w_accept) begin
                    w_nxt_wren = 1'b1;
                    w_nxt_din  = w_sel_data;
                    w_nxt_cnt  = w_cnt_inc;
                    if (w_sel_last) begin
                        if (w_cnt_inc >= LEN_W'(MIN_LEN)) begin
                            w_nxt_eod    = 1'b1;
                            w_nxt_frames = r_frame_cnt + 16'd1;
                            w_nxt_grant  = 2'b00;
                            w_nxt_state  = S_IDLE;
                        end else begin
                            w_nxt_state = S_PAD;
                        end
                    end else if (w_cnt_inc == LEN_W'(MAX_LEN)) begin
                        w_nxt_eod    = 1'b1;
                        w_nxt_frames = r_frame_cnt + 16'd1;
                        w_nxt_truncs = r_trunc_cnt + 16'd1;
                        w_nxt_state  = S_DRAIN;
                    end else begin
                        w_nxt_state = S_XFER;
                    end
                end else begin
                    w_nxt_state = S_XFER;
                end
            end
            S_PAD: begin
                if (!bus.fifo_afull) begin
                    w_nxt_wren = 1'b1;
                    w_nxt_din  = 8'h00;
                    w_nxt_cnt  = w_cnt_inc;
                    if (w_cnt_inc >= LEN_W'(MIN_LEN)) begin
                        w_nxt_eod    = 1'b1;
                        w_nxt_frames = r_frame_cnt + 16'd1;
                        w_nxt_grant  = 2'b00;
                        w_nxt_state  = S_IDLE;
                    end else begin
                        w_nxt_state = S_PAD;
                    end
                end else begin
                    w_nxt_state = S_PAD;
                end
            end
            S_DRAIN: begin
                if (w_accept && w_sel_last) begin
                    w_nxt_grant = 2'b00;
                    w_nxt_state = S_IDLE;
                end else begin
                    w_nxt_state = S_DRAIN;
                end
            end
            default: begin
                w_nxt_grant = 2'b00;
                w_nxt_state = S_IDLE;
            end
        endcase
        w_nxt_busy = (w_nxt_state != S_IDLE);
    end

    // State and registered outputs; reset abandons any frame without an EOD.
    always_ff @(posedge REF_CLK) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_grant       <= 2'b00;
            r_last_served <= 1'b1;
            r_byte_cnt    <= '0;
            r_din         <= 8'h00;
            r_eod         <= 1'b0;
            r_wren        <= 1'b0;
            r_busy        <= 1'b0;
            r_frame_cnt   <= 16'd0;
            r_trunc_cnt   <= 16'd0;
        end else begin
            r_state       <= w_nxt_state;
            r_grant       <= w_nxt_grant;
            r_last_served <= w_nxt_ls;
            r_byte_cnt    <= w_nxt_cnt;
            r_din         <= w_nxt_din;
            r_eod         <= w_nxt_eod;
            r_wren        <= w_nxt_wren;
            r_busy        <= w_nxt_busy;
            r_frame_cnt   <= w_nxt_frames;
            r_trunc_cnt   <= w_nxt_truncs;
        end
    end
endmodule

// File: tb/tb_tx_frame_arbiter.sv
// Randomized scoreboard bench for tx_frame_arbiter: a frame-level model predicts
// grant order and the exact FIFO write stream; a negedge monitor compares.
module tb_tx_frame_arbiter;
    localparam int MIN_LEN = 60;
    localparam int MAX_LEN = 1514;

    logic        REF_CLK = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [1:0]  grant;
    logic        busy;
    logic [15:0] frame_count;
    logic [15:0] trunc_count;

    tx_frame_arbiter_if bus();

    tx_frame_arbiter #(.MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN), .LEN_W(11)) dut (
        .REF_CLK     (REF_CLK),
        .rst         (rst),
        .enable      (enable),
        .bus         (bus.slave),
        .grant       (grant),
        .busy        (busy),
        .frame_count (frame_count),
        .trunc_count (trunc_count)
    );

    always #10 REF_CLK = ~REF_CLK;

    int checks = 0;
    int passes = 0;
    logic [8:0] exp_q[$];   // {eod, data}
    logic [1:0] gq[$];      // expected grant sequence
    logic [8:0] src0_q[$];  // {last, data}
    logic [8:0] src1_q[$];
    int f0len[$];
    int f1len[$];
    int model_ls = 1;
    int model_frames = 0;
    int model_trunc = 0;
    bit sb_on = 1'b0;
    bit afull_chk = 1'b0;
    logic prev_afull = 1'b0;
    logic [1:0] prev_grant = 2'b00;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Monitor: pops the scoreboard on every FIFO write and every new grant.
    always @(negedge REF_CLK) begin
        if (!rst && sb_on) begin
            if (bus.fifo_wren) begin
                check("write_after_afull", int'(prev_afull), 0);
                if (exp_q.size() == 0) check("unexpected_write", 1, 0);
                else check("write_eod_data", int'({bus.fifo_EOD_in, bus.fifo_din}), int'(exp_q.pop_front()));
            end
            if (prev_grant == 2'b00 && grant != 2'b00) begin
                if (gq.size() == 0) check("unexpected_grant", int'(grant), 0);
                else check("grant_order", int'(grant), int'(gq.pop_front()));
            end
            if (bus.req0_ready && !grant[0]) check("ready0_not_granted", 1, 0);
            if (bus.req1_ready && !grant[1]) check("ready1_not_granted", 1, 0);
            if (afull_chk && bus.fifo_afull && (bus.req0_ready || bus.req1_ready))
                check("ready_while_afull", 1, 0);
        end
        prev_afull <= bus.fifo_afull;
        prev_grant <= grant;
    end

    task automatic set_src(input int s, input logic v, input logic [8:0] it);
        if (s == 0) begin
            bus.req0_valid = v; bus.req0_data = it[7:0]; bus.req0_last = it[8];
        end else begin
            bus.req1_valid = v; bus.req1_data = it[7:0]; bus.req1_last = it[8];
        end
    endtask

    // Reference model: round-robin over whole frames, then pad/truncate by length rules.
    task automatic build_phase();
        int i0 = 0;
        int i1 = 0;
        while (i0 < f0len.size() || i1 < f1len.size()) begin
            int s, len, n, tot;
            bit h0, h1;
            h0 = (i0 < f0len.size());
            h1 = (i1 < f1len.size());
            if (h0 && h1) s = (model_ls == 1) ? 0 : 1;
            else s = h0 ? 0 : 1;
            model_ls = s;
            if (s == 0) begin len = f0len[i0]; i0++; end
            else begin len = f1len[i1]; i1++; end
            gq.push_back(s == 0 ? 2'b01 : 2'b10);
            n   = (len > MAX_LEN) ? MAX_LEN : len;
            tot = (n < MIN_LEN) ? MIN_LEN : n;
            for (int k = 0; k < len; k++) begin
                logic [7:0] b;
                b = 8'($urandom);
                if (s == 0) src0_q.push_back({(k == len - 1), b});
                else src1_q.push_back({(k == len - 1), b});
                if (k < n) exp_q.push_back({(k == tot - 1), b});
            end
            for (int k = n; k < tot; k++) exp_q.push_back({(k == tot - 1), 8'h00});
            model_frames++;
            if (len > MAX_LEN) model_trunc++;
        end
        f0len.delete();
        f1len.delete();
    endtask

    task automatic drive(input int s);
        logic [8:0] it;
        bit first = 1'b1;
        bit acc;
        int budget;
        while ((s == 0 ? src0_q.size() : src1_q.size()) > 0) begin
            it = (s == 0) ? src0_q.pop_front() : src1_q.pop_front();
            if (!first && $urandom_range(0, 3) == 0) begin
                set_src(s, 1'b0, 9'h000);
                repeat ($urandom_range(1, 3)) @(posedge REF_CLK);
                #1;
            end
            set_src(s, 1'b1, it);
            budget = 0;
            acc = 1'b0;
            while (!acc && budget < 5000) begin
                @(negedge REF_CLK);
                acc = (s == 0) ? bus.req0_ready : bus.req1_ready;
                @(posedge REF_CLK);
                #1;
                budget++;
            end
            if (!acc) begin
                check("source_accept_timeout", s, -1);
                if (s == 0) src0_q.delete(); else src1_q.delete();
            end
            first = it[8];
        end
        set_src(s, 1'b0, 9'h000);
    endtask

    // mode: 0 afull low, 1 random afull, 2 afull high 5 of every 10 cycles.
    task automatic run_phase(input int mode);
        bit d0 = 1'b0;
        bit d1 = 1'b0;
        build_phase();
        afull_chk = (mode != 0);
        fork
            begin drive(0); d0 = 1'b1; end
            begin drive(1); d1 = 1'b1; end
            begin
                int c = 0;
                while (!(d0 && d1)) begin
                    if (mode == 1) bus.fifo_afull = ($urandom_range(0, 3) == 0);
                    else if (mode == 2) bus.fifo_afull = ((c % 10) >= 5);
                    else bus.fifo_afull = 1'b0;
                    c++;
                    @(posedge REF_CLK);
                    #1;
                end
                bus.fifo_afull = 1'b0;
            end
        join
        for (int w = 0; w < 2000 && (exp_q.size() != 0 || busy); w++) @(negedge REF_CLK);
        check("writes_outstanding", exp_q.size(), 0);
        check("grants_outstanding", gq.size(), 0);
        check("frame_count", int'(frame_count), model_frames & 16'hFFFF);
        check("trunc_count", int'(trunc_count), model_trunc & 16'hFFFF);
        afull_chk = 1'b0;
        @(posedge REF_CLK);
        #1;
    endtask

    initial begin
        set_src(0, 1'b0, 9'h000);
        set_src(1, 1'b0, 9'h000);
        bus.fifo_afull = 1'b0;
        repeat (3) @(posedge REF_CLK);
        @(negedge REF_CLK);
        check("reset_grant", int'(grant), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_wren_eod", int'({bus.fifo_wren, bus.fifo_EOD_in}), 0);
        check("reset_frame_count", int'(frame_count), 0);
        check("reset_trunc_count", int'(trunc_count), 0);
        @(posedge REF_CLK);
        #1;
        rst = 1'b0;
        enable = 1'b1;
        sb_on = 1'b1;

        f0len.push_back(64);                          run_phase(0);
        f1len.push_back(10);                          run_phase(0);
        repeat (3) begin f0len.push_back(60); f1len.push_back(60); end
        run_phase(0);
        f0len.push_back(1600); f1len.push_back(20);   run_phase(0);
        f0len.push_back(100);                         run_phase(2);
        f0len.push_back(MAX_LEN); f1len.push_back(MAX_LEN + 1); run_phase(0);
        for (int r = 0; r < 6; r++) begin
            int pick[4];
            pick[0] = 1; pick[1] = MIN_LEN - 1; pick[2] = MIN_LEN; pick[3] = MIN_LEN + 1;
            repeat ($urandom_range(0, 3)) f0len.push_back($urandom_range(0, 1) ? pick[$urandom_range(0, 3)] : $urandom_range(1, 200));
            repeat ($urandom_range(1, 3)) f1len.push_back($urandom_range(0, 1) ? pick[$urandom_range(0, 3)] : $urandom_range(1, 200));
            run_phase(1);
        end

        // enable dropped mid-frame: the frame finishes, then nothing is granted.
        f0len.push_back(30);
        fork
            run_phase(0);
            begin repeat (5) @(posedge REF_CLK); #1; enable = 1'b0; end
        join
        f1len.push_back(20);
        fork
            run_phase(0);
            begin
                repeat (20) begin
                    @(negedge REF_CLK);
                    check("no_grant_enable_low", int'({grant, busy}), 0);
                end
                enable = 1'b1;
            end
        join

        // Reset in the middle of a frame.
        sb_on = 1'b0;
        set_src(0, 1'b1, 9'h0A5);
        repeat (10) @(posedge REF_CLK);
        #1;
        rst = 1'b1;
        set_src(0, 1'b0, 9'h000);
        @(posedge REF_CLK);
        #1;
        rst = 1'b0;
        @(negedge REF_CLK);
        check("midreset_grant", int'(grant), 0);
        check("midreset_busy", int'(busy), 0);
        check("midreset_frame_count", int'(frame_count), 0);
        check("midreset_trunc_count", int'(trunc_count), 0);
        check("midreset_no_eod", int'({bus.fifo_wren, bus.fifo_EOD_in}), 0);
        model_ls = 1;
        model_frames = 0;
        model_trunc = 0;
        exp_q.delete();
        gq.delete();
        @(posedge REF_CLK);
        #1;
        sb_on = 1'b1;
        f0len.push_back(12); f1len.push_back(70);     run_phase(1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
